// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin owner selection for one shared mux-selected datapath.
// Each tenure lasts at most MAX_HOLD cycles. One dead cycle separates tenures so the
// mux tree settles before a new owner drives it.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   reset  - synchronous, active-high reset
//   req    - request vector, bit i high while requester i wants the resource
//   gnt    - registered one-hot grant (all-zero when nobody owns the resource)
//   sel    - registered mux select: index of the current or most recent owner
//   valid  - registered, high whenever a gnt bit is high
//   expire - registered one-cycle pulse in the dead cycle after a MAX_HOLD cut-off
module rr_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned SEL_W    = $clog2(N_REQ),
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             expire
);

    // One extra bit so that ptr + offset can exceed N_REQ-1 before wrapping.
    localparam int unsigned IDX_W = SEL_W + 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(N_REQ - 1);
    localparam logic [IDX_W-1:0] N_IDX      = IDX_W'(N_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               expire_q, expire_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [SEL_W-1:0]   ptr_after_owner;

    // Rotating priority search starting at ptr; explicit wrap keeps it correct
    // for non-power-of-2 N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + IDX_W'(k);
            if (cand >= N_IDX) begin
                cand = cand - N_IDX;
            end
            if (!win_found && req[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // Priority moves to the requester just after the outgoing owner.
    always_comb begin
        if (owner_q == LAST_IDX) begin
            ptr_after_owner = '0;
        end else begin
            ptr_after_owner = owner_q + SEL_W'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        expire_d = expire_q;

        case (state_q)
            IDLE, RELEASE: begin
                gnt_d    = '0;
                valid_d  = 1'b0;
                expire_d = 1'b0;
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << win_idx;
                    sel_d   = win_idx;
                    owner_d = win_idx;
                    valid_d = 1'b1;
                    hold_d  = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT: begin
                expire_d = 1'b0;
                if (!req[owner_q]) begin
                    // Voluntary release wins over a coincident hold limit.
                    state_d = RELEASE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = ptr_after_owner;
                end else if (hold_q == HOLD_LIMIT) begin
                    state_d  = RELEASE;
                    gnt_d    = '0;
                    valid_d  = 1'b0;
                    ptr_d    = ptr_after_owner;
                    expire_d = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                valid_d  = 1'b0;
                expire_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            hold_q   <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            expire_q <= expire_d;
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign valid  = valid_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: scoreboard bench for rr_bus_arbiter (N_REQ=4, MAX_HOLD=4).
// The driver applies directed then random req/reset patterns. For every edge it
// pushes the outputs a behavioural model predicts. A monitor compares the DUT
// against those predictions one time unit after each rising edge.
module tb_rr_bus_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned MH  = 4;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [SW-1:0] sel;
        logic          valid;
        logic          expire;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;
    logic          valid;
    logic          expire;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    exp_t exp_q[$];

    // Reference model: who owns the bus, for how long, and who is next in line.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_len   = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    bit m_exp   = 0;

    rr_bus_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .valid  (valid),
        .expire (expire)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic r, input logic [N-1:0] q);
        int w;
        if (r) begin
            m_busy = 0; m_owner = 0; m_len = 0; m_ptr = 0; m_sel = 0; m_exp = 0;
        end else if (m_busy) begin
            if (!q[m_owner] || m_len == MH) begin
                m_exp  = q[m_owner];
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else begin
                m_len = m_len + 1;
            end
        end else begin
            m_exp = 0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && q[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_len   = 1;
                m_sel   = w;
            end
        end
    endtask

    // Apply inputs for the coming edge, queue the predicted result, wait out the cycle.
    task automatic drive(input logic r, input logic [N-1:0] q);
        exp_t e;
        reset = r;
        req   = q;
        model_step(r, q);
        e.gnt    = m_busy ? (N'(1) << m_owner) : '0;
        e.sel    = SW'(m_sel);
        e.valid  = m_busy;
        e.expire = m_exp;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty cycle=%0d got gnt=%b with no prediction queued", cycle, gnt);
            end else begin
                e = exp_q.pop_front();
                if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid || expire !== e.expire) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got gnt=%b sel=%0d valid=%b expire=%b want gnt=%b sel=%0d valid=%b expire=%b",
                             cycle, gnt, sel, valid, expire, e.gnt, e.sel, e.valid, e.expire);
                end
                checks++;
                if (!(gnt == '0 || $onehot(gnt)) || valid !== (|gnt)) begin
                    failures++;
                    $display("FAIL invariant cycle=%0d got gnt=%b valid=%b want one-hot/zero gnt and valid=|gnt",
                             cycle, gnt, valid);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cycle=%0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] cur;
        int           left;

        // Reset held with all requests high, then full contention rotation.
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1111);
        for (int i = 0; i < 24; i++) drive(1'b0, 4'b1111);

        // Single requester holding two cycles then dropping.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000);

        // Wrap search from ptr=2 to requester 0, then from ptr=1 to requester 3.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0010);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0001);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b1001);
        drive(1'b0, 4'b1001);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);

        // Owner drops on the same edge its tenure reaches the limit.
        drive(1'b1, 4'b0000);
        for (int i = 0; i < MH; i++) drive(1'b0, 4'b0001);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b1111);
        drive(1'b0, 4'b1111);

        // Reset in the middle of a tenure, then a fresh full tenure.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0100);
        drive(1'b1, 4'b0100);
        for (int i = 0; i < 7; i++) drive(1'b0, 4'b0100);

        // Random request patterns held for random lengths, with rare resets.
        cur  = '0;
        left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (left == 0) begin
                cur  = N'($urandom);
                left = int'($urandom_range(1, 12));
            end
            left--;
            if ($urandom_range(0, 7) == 0) cur[$urandom_range(0, N - 1)] ^= 1'b1;
            drive(($urandom_range(0, 99) == 0), cur);
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d unchecked predictions want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one mux-selected datapath resource (e.g. the write-back/bus mux tree built from 2:1 muxes) among N_REQ requesters.
- Issues a one-hot grant and a binary select for the mux tree.
- Bounds each tenure to MAX_HOLD cycles.
- Inserts one dead cycle between tenures so the structural mux settles before a new owner drives it.

Parameters:
- N_REQ, 4: number of requesters, legal range 2..8.
- SEL_W, $clog2(N_REQ): select width. Derived; do not override.
- MAX_HOLD, 8: maximum consecutive granted cycles per tenure, legal range 1..255.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req, input, N_REQ: request vector. Bit i is high while requester i wants the resource.
- gnt, output, N_REQ: one-hot grant, or all-zero. Registered.
- sel, output, SEL_W: mux select, equal to the index of the current or most recent owner. Registered.
- valid, output, 1: high when any gnt bit is high. Registered.
- expire, output, 1: one-cycle pulse when a tenure is force-ended by MAX_HOLD. Registered.

Behaviour:
- Reset:
  - Takes effect on any rising edge with reset=1, including mid-tenure.
  - Reset values: gnt=0, sel=0, valid=0, expire=0, state=IDLE, ptr=0, hold_cnt=0.
- Internal state:
  - ptr: index of the highest-priority requester.
  - owner: index of the current owner.
  - hold_cnt: 8-bit tenure counter.
- Arbitration function:
  - Winner is the first i with req[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
  - The search wraps at N_REQ-1 to 0 for non-power-of-2 N_REQ.
- State IDLE:
  - gnt=0, valid=0.
  - If any req bit is set: next state GRANT; gnt<=onehot(winner), sel<=winner, owner<=winner, valid<=1, hold_cnt<=1.
  - Otherwise stay in IDLE.
- State GRANT:
  - If req[owner]=0: next state RELEASE; expire<=0.
  - Else if hold_cnt==MAX_HOLD: next state RELEASE; expire<=1.
  - Else: hold_cnt<=hold_cnt+1 and gnt is held.
  - On any exit: gnt<=0, valid<=0, ptr<=(owner+1) mod N_REQ.
  - If the owner drops req on the same edge that hold_cnt==MAX_HOLD, the drop wins and expire=0.
  - Changes on req bits of non-owners are ignored.
- State RELEASE (dead cycle):
  - gnt=0 and valid=0.
  - expire is high only in this state, and only after a forced end.
  - Arbitrates exactly like IDLE, using the updated ptr: on a winner, go to GRANT; otherwise go to IDLE.
  - expire<=0 on leaving RELEASE.
- sel:
  - Changes only when a grant is issued.
  - Holds the last owner through RELEASE and IDLE, so the mux output stays stable.
- Latency:
  - A req sampled high in IDLE gives gnt visible after that edge, i.e. one cycle.
  - Back-to-back tenures are separated by exactly one cycle with gnt=0.
- Throughput: with continuous contention, each tenure is MAX_HOLD cycles followed by 1 dead cycle.
- Invariants:
  - gnt is always one-hot or zero.
  - valid equals the OR of gnt bits.
  - hold_cnt never exceeds MAX_HOLD.
  - No requester is granted twice while another requester has been continuously requesting.

Test Plan (N_REQ=4, MAX_HOLD=4):
1. Reset: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, sel=0, valid=0, expire=0 throughout. Release reset -> the next edge gives gnt=4'b0001, sel=0.
2. Single requester: req=4'b0100, hold 2 cycles, then drop ->
   - gnt=4'b0100, sel=2, valid=1 one edge after req.
   - After the drop edge: gnt=0, expire=0, sel stays 2.
   - Next edge: IDLE.
3. Full contention: req=4'b1111 held constant ->
   - gnt sequence is 0001 x4, 0000 (expire=1), 0010 x4, 0000 (expire=1), 0100 x4, 0000, 1000 x4, 0000, 0001.
   - sel tracks 0, 1, 2, 3, 0.
4. Wrap search: after owner 1 releases (ptr=2), req=4'b0001 -> the next grant is 4'b0001 after the dead cycle. Then req=4'b1001 with ptr=1 -> grant 4'b1000.
5. Simultaneous end: owner 0 drops req on the same edge its hold_cnt reaches 4 -> RELEASE with expire=0, ptr=1.
6. Reset mid-tenure: reset=1 while gnt=4'b0100 with hold_cnt=2 -> the next edge gives gnt=0, sel=0, valid=0. After deassertion with req=4'b0100 -> gnt=4'b0100 and a fresh hold_cnt=1 (full 4-cycle tenure).
